// File: rtl/lcd_pkg.sv
// Shared constants, opcode masks, FSM states and address-counter helpers
// for the HD44780 4-bit receive-side responder.
package lcd_pkg;

    localparam logic [6:0]  LCD_LINE1_BASE = 7'h40;
    localparam int unsigned LCD_LINE_LEN   = 40;
    localparam int unsigned LCD_DDRAM_SIZE = 80;
    localparam logic [7:0]  LCD_SPACE      = 8'h20;

    localparam logic [7:0] OP_SET_DDRAM = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM = 8'h40;
    localparam logic [7:0] OP_FUNC_SET  = 8'h20;
    localparam logic [7:0] OP_SHIFT     = 8'h10;
    localparam logic [7:0] OP_DISP_CTRL = 8'h08;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h01;

    typedef enum logic [1:0] {ST_FILL, ST_IDLE, ST_EXEC} lcd_state_e;

    typedef enum logic [3:0] {
        INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISP,
        INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
    } lcd_ins_e;

    // The highest set bit of an instruction byte selects its class.
    function automatic lcd_ins_e lcd_decode(input logic [7:0] b);
        if ((b & OP_SET_DDRAM) != 8'h00) return INS_DDRAM;
        if ((b & OP_SET_CGRAM) != 8'h00) return INS_CGRAM;
        if ((b & OP_FUNC_SET)  != 8'h00) return INS_FUNC;
        if ((b & OP_SHIFT)     != 8'h00) return INS_SHIFT;
        if ((b & OP_DISP_CTRL) != 8'h00) return INS_DISP;
        if ((b & OP_ENTRY)     != 8'h00) return INS_ENTRY;
        if ((b & OP_HOME)      != 8'h00) return INS_HOME;
        if ((b & OP_CLEAR)     != 8'h00) return INS_CLEAR;
        return INS_NOP;
    endfunction

    function automatic logic [6:0] ac_to_idx(input logic [6:0] ac);
        return ac[6] ? 7'(LCD_LINE_LEN) + {1'b0, ac[5:0]} : {1'b0, ac[5:0]};
    endfunction

    function automatic logic [6:0] ac_inc(input logic [6:0] ac);
        if (ac == 7'(LCD_LINE_LEN - 1))                  return LCD_LINE1_BASE;
        if (ac == LCD_LINE1_BASE + 7'(LCD_LINE_LEN - 1)) return 7'h00;
        return ac + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] ac);
        if (ac == 7'h00)          return LCD_LINE1_BASE + 7'(LCD_LINE_LEN - 1);
        if (ac == LCD_LINE1_BASE) return 7'(LCD_LINE_LEN - 1);
        return ac - 7'd1;
    endfunction

    // Addresses past the end of a line snap back to that line's start.
    function automatic logic [6:0] ac_clamp(input logic [6:0] ac);
        if ({1'b0, ac[5:0]} >= 7'(LCD_LINE_LEN)) return {ac[6], 6'd0};
        return ac;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one write port, one registered read port (old data on
// a same-cycle read/write collision).
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [LCD_DDRAM_SIZE];
    logic [7:0] rd_data_d, rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < 7'(LCD_DDRAM_SIZE))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = 8'h00;
        if (rd_addr < 7'(LCD_DDRAM_SIZE)) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= 8'h00;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Receive-side HD44780 model: samples the controller's pins, rebuilds bytes
// from nibbles, executes instructions and data writes, emulates busy timing.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_SHORT = 1000,
    parameter int unsigned BUSY_LONG  = 41000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       cmd_rs,
    output logic       busy,
    output logic       timing_err,
    output logic       four_bit_mode,
    output logic       two_line,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] cursor_idx
);

    localparam int unsigned CNT_W = $clog2(BUSY_LONG + 1);

    // {rs, rw, data[3:0]}
    logic [5:0] pin_s1_q, pin_s1_d, pin_s2_q, pin_s2_d;
    logic [2:0] e_q, e_d;
    logic       strobe;
    logic       stb_q, stb_d, stb_rs_q, stb_rs_d;
    logic [3:0] stb_nib_q, stb_nib_d, hi_nib_q, hi_nib_d;
    logic       phase_hi_q, phase_hi_d;
    logic       cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;

    lcd_state_e state_q, state_d;
    logic [6:0] fill_idx_q, fill_idx_d, ac_q, ac_d;
    logic       id_q, id_d, cgram_q, cgram_d;
    logic       four_bit_q, four_bit_d, two_line_q, two_line_d;
    logic       disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic       terr_q, terr_d;
    logic       pend_v_q, pend_v_d, pend_rs_q, pend_rs_d, ex_rs_q, ex_rs_d;
    logic [7:0] pend_byte_q, pend_byte_d, ex_byte_q, ex_byte_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

    logic       enter_4bit;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    // Falling E seen between the second and third synchronizer stages.
    assign strobe = ~e_q[1] & e_q[2] & ~pin_s2_q[4];
    assign busy   = (state_q == ST_FILL) || (busy_cnt_q != '0);

    always_comb begin
        pin_s1_d    = {lcd_rs, lcd_rw, lcd_data};
        pin_s2_d    = pin_s1_q;
        e_d         = {e_q[1:0], lcd_e};
        stb_d       = strobe;
        stb_rs_d    = pin_s2_q[5];
        stb_nib_d   = pin_s2_q[3:0];
        hi_nib_d    = hi_nib_q;
        phase_hi_d  = phase_hi_q;
        cmd_valid_d = 1'b0;
        cmd_byte_d  = cmd_byte_q;
        cmd_rs_d    = cmd_rs_q;
        if (stb_q) begin
            if (!four_bit_q) begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = {stb_nib_q, 4'h0};
                cmd_rs_d    = stb_rs_q;
            end else if (phase_hi_q) begin
                hi_nib_d   = stb_nib_q;
                phase_hi_d = 1'b0;
            end else begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = {hi_nib_q, stb_nib_q};
                cmd_rs_d    = stb_rs_q;
                phase_hi_d  = 1'b1;
            end
        end
        if (enter_4bit) phase_hi_d = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx_q;
        ac_d        = ac_q;
        id_d        = id_q;
        cgram_d     = cgram_q;
        four_bit_d  = four_bit_q;
        two_line_d  = two_line_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        terr_d      = terr_q;
        pend_v_d    = pend_v_q;
        pend_byte_d = pend_byte_q;
        pend_rs_d   = pend_rs_q;
        ex_byte_d   = ex_byte_q;
        ex_rs_d     = ex_rs_q;
        enter_4bit  = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = fill_idx_q;
        wr_data     = LCD_SPACE;
        busy_cnt_d  = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;

        if (strobe && busy) terr_d = 1'b1;
        // Bytes finishing outside IDLE park in the one-entry pending slot.
        if (cmd_valid_q && (state_q != ST_IDLE)) begin
            if (pend_v_q) terr_d = 1'b1;
            pend_v_d    = 1'b1;
            pend_byte_d = cmd_byte_q;
            pend_rs_d   = cmd_rs_q;
        end

        unique case (state_q)
            ST_FILL: begin
                wr_en      = 1'b1;
                fill_idx_d = fill_idx_q + 7'd1;
                if (fill_idx_q == 7'(LCD_DDRAM_SIZE - 1)) begin
                    fill_idx_d = 7'd0;
                    state_d    = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (pend_v_q) begin
                    state_d   = ST_EXEC;
                    ex_byte_d = pend_byte_q;
                    ex_rs_d   = pend_rs_q;
                    pend_v_d  = cmd_valid_q;
                    if (cmd_valid_q) begin
                        pend_byte_d = cmd_byte_q;
                        pend_rs_d   = cmd_rs_q;
                    end
                end else if (cmd_valid_q) begin
                    state_d   = ST_EXEC;
                    ex_byte_d = cmd_byte_q;
                    ex_rs_d   = cmd_rs_q;
                end
            end
            ST_EXEC: begin
                state_d    = ST_IDLE;
                busy_cnt_d = CNT_W'(BUSY_SHORT);
                if (ex_rs_q) begin
                    if (!cgram_q) begin
                        wr_en   = 1'b1;
                        wr_addr = ac_to_idx(ac_q);
                        wr_data = ex_byte_q;
                        ac_d    = id_q ? ac_inc(ac_q) : ac_dec(ac_q);
                    end
                end else begin
                    case (lcd_decode(ex_byte_q))
                        INS_DDRAM: begin
                            ac_d    = ac_clamp(ex_byte_q[6:0]);
                            cgram_d = 1'b0;
                        end
                        INS_CGRAM: cgram_d = 1'b1;
                        INS_FUNC: begin
                            two_line_d = ex_byte_q[3];
                            if (!ex_byte_q[4] && !four_bit_q) begin
                                four_bit_d = 1'b1;
                                enter_4bit = 1'b1;
                            end
                        end
                        INS_SHIFT: begin
                            if (!ex_byte_q[3]) ac_d = ex_byte_q[2] ? ac_inc(ac_q) : ac_dec(ac_q);
                        end
                        INS_DISP: begin
                            disp_d  = ex_byte_q[2];
                            cur_d   = ex_byte_q[1];
                            blink_d = ex_byte_q[0];
                        end
                        INS_ENTRY: id_d = ex_byte_q[1];
                        INS_HOME: begin
                            ac_d       = 7'h00;
                            cgram_d    = 1'b0;
                            busy_cnt_d = CNT_W'(BUSY_LONG);
                        end
                        INS_CLEAR: begin
                            ac_d       = 7'h00;
                            id_d       = 1'b1;
                            cgram_d    = 1'b0;
                            busy_cnt_d = CNT_W'(BUSY_LONG);
                            state_d    = ST_FILL;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_s1_q    <= '0;
            pin_s2_q    <= '0;
            e_q         <= '0;
            stb_q       <= 1'b0;
            stb_rs_q    <= 1'b0;
            stb_nib_q   <= '0;
            hi_nib_q    <= '0;
            phase_hi_q  <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
            cmd_rs_q    <= 1'b0;
            state_q     <= ST_FILL;
            fill_idx_q  <= '0;
            ac_q        <= '0;
            id_q        <= 1'b1;
            cgram_q     <= 1'b0;
            four_bit_q  <= 1'b0;
            two_line_q  <= 1'b0;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            terr_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_byte_q <= '0;
            pend_rs_q   <= 1'b0;
            ex_byte_q   <= '0;
            ex_rs_q     <= 1'b0;
            busy_cnt_q  <= '0;
        end else begin
            pin_s1_q    <= pin_s1_d;
            pin_s2_q    <= pin_s2_d;
            e_q         <= e_d;
            stb_q       <= stb_d;
            stb_rs_q    <= stb_rs_d;
            stb_nib_q   <= stb_nib_d;
            hi_nib_q    <= hi_nib_d;
            phase_hi_q  <= phase_hi_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_rs_q    <= cmd_rs_d;
            state_q     <= state_d;
            fill_idx_q  <= fill_idx_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            cgram_q     <= cgram_d;
            four_bit_q  <= four_bit_d;
            two_line_q  <= two_line_d;
            disp_q      <= disp_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            terr_q      <= terr_d;
            pend_v_q    <= pend_v_d;
            pend_byte_q <= pend_byte_d;
            pend_rs_q   <= pend_rs_d;
            ex_byte_q   <= ex_byte_d;
            ex_rs_q     <= ex_rs_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    lcd_ddram u_ddram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign cmd_valid     = cmd_valid_q;
    assign cmd_byte      = cmd_byte_q;
    assign cmd_rs        = cmd_rs_q;
    assign timing_err    = terr_q;
    assign four_bit_mode = four_bit_q;
    assign two_line      = two_line_q;
    assign display_on    = disp_q;
    assign cursor_on     = cur_q;
    assign blink_on      = blink_q;
    assign cursor_idx    = ac_to_idx(ac_q);

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for the HD44780 responder: expected bytes queued at stimulus
// time and popped by a monitor on cmd_valid; state and DDRAM checked directly.
module tb_lcd_hd44780_responder;

    logic       clk;
    logic       rst_n;
    logic [3:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       cmd_valid, cmd_rs, busy, timing_err;
    logic [7:0] cmd_byte;
    logic       four_bit_mode, two_line, display_on, cursor_on, blink_on;
    logic [6:0] cursor_idx;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] exp_ram [80];
    logic       bench4;

    lcd_hd44780_responder #(.BUSY_SHORT(1000), .BUSY_LONG(41000)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_e(lcd_e), .rd_addr(rd_addr), .rd_data(rd_data),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_rs(cmd_rs),
        .busy(busy), .timing_err(timing_err), .four_bit_mode(four_bit_mode),
        .two_line(two_line), .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .cursor_idx(cursor_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #950000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected actual %03h expected none", {cmd_rs, cmd_byte});
            end else begin
                chk("cmd_byte", {23'd0, cmd_rs, cmd_byte}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_nib(input logic rs, input logic [3:0] nib);
        lcd_rs   = rs;
        lcd_rw   = 1'b0;
        lcd_data = nib;
        @(negedge clk);
        lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        if (bench4) begin
            exp_q.push_back({rs, b});
            send_nib(rs, b[7:4]);
            send_nib(rs, b[3:0]);
        end else begin
            exp_q.push_back({rs, b[7:4], 4'h0});
            send_nib(rs, b[7:4]);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (8) @(negedge clk);
        while (busy && n < 50000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic measure_busy(input string name, input int exp_len);
        int n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy && n < 50000) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp_len);
    endtask

    task automatic wait_fill(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n >= 79 && n <= 82) ? 32'd1 : {16'hbad0, 16'(n)}, 32'd1);
    endtask

    task automatic check_ram(input string name);
        int bad = 0;
        int first_i = -1;
        logic [7:0] first_act = 8'h00;
        for (int i = 0; i < 80; i++) begin
            rd_addr = 7'(i);
            @(negedge clk);
            if (rd_data !== exp_ram[i]) begin
                if (first_i < 0) begin
                    first_i   = i;
                    first_act = rd_data;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s idx %0d actual %02h expected %02h (%0d bad)",
                     name, first_i, first_act, exp_ram[first_i], bad);
        end
    endtask

    task automatic read_chk(input string name, input int idx, input logic [7:0] exp);
        rd_addr = 7'(idx);
        @(negedge clk);
        chk(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_data = 4'h0; rd_addr = 7'd0; bench4 = 1'b0;
        for (int i = 0; i < 80; i++) exp_ram[i] = 8'h20;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_four_bit", {31'd0, four_bit_mode}, 32'd0);
        chk("rst_timing_err", {31'd0, timing_err}, 32'd0);
        chk("rst_display_on", {31'd0, display_on}, 32'd0);
        chk("rst_cursor_idx", {25'd0, cursor_idx}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        wait_fill("fill_len");
        check_ram("fill_ram");
        chk("fill_cursor_idx", {25'd0, cursor_idx}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            send_byte(1'b0, 8'h30);
            wait_idle();
        end
        chk("still_8bit", {31'd0, four_bit_mode}, 32'd0);
        send_byte(1'b0, 8'h20);
        wait_idle();
        bench4 = 1'b1;
        chk("four_bit_on", {31'd0, four_bit_mode}, 32'd1);
        chk("two_line_off", {31'd0, two_line}, 32'd0);

        send_byte(1'b0, 8'h28);
        measure_busy("short_busy_len", 1000);
        chk("two_line_on", {31'd0, two_line}, 32'd1);
        send_byte(1'b0, 8'h0C); wait_idle();
        chk("display_on", {31'd0, display_on}, 32'd1);
        chk("cursor_off", {31'd0, cursor_on}, 32'd0);
        chk("blink_off", {31'd0, blink_on}, 32'd0);
        send_byte(1'b0, 8'h06); wait_idle();
        send_byte(1'b1, 8'h48); wait_idle();
        send_byte(1'b1, 8'h69); wait_idle();
        chk("text_cursor_idx", {25'd0, cursor_idx}, 32'd2);
        exp_ram[0] = 8'h48;
        exp_ram[1] = 8'h69;

        send_byte(1'b0, 8'hA7); wait_idle();
        chk("addr27_idx", {25'd0, cursor_idx}, 32'd39);
        send_byte(1'b1, 8'h41); wait_idle();
        send_byte(1'b1, 8'h42); wait_idle();
        chk("wrap_cursor_idx", {25'd0, cursor_idx}, 32'd41);
        exp_ram[39] = 8'h41;
        exp_ram[40] = 8'h42;
        check_ram("text_ram");

        send_byte(1'b0, 8'h04); wait_idle();
        send_byte(1'b0, 8'h80); wait_idle();
        send_byte(1'b1, 8'h43); wait_idle();
        chk("dec_wrap_idx", {25'd0, cursor_idx}, 32'd79);
        exp_ram[0] = 8'h43;
        send_byte(1'b0, 8'h06); wait_idle();
        send_byte(1'b0, 8'hB0); wait_idle();
        chk("clamp_line0_idx", {25'd0, cursor_idx}, 32'd0);
        send_byte(1'b0, 8'hEF); wait_idle();
        chk("clamp_line1_idx", {25'd0, cursor_idx}, 32'd40);
        send_byte(1'b0, 8'h10); wait_idle();
        chk("shift_left_idx", {25'd0, cursor_idx}, 32'd39);
        send_byte(1'b0, 8'h40); wait_idle();
        send_byte(1'b1, 8'h55); wait_idle();
        chk("cgram_cursor_idx", {25'd0, cursor_idx}, 32'd39);
        send_byte(1'b0, 8'h80); wait_idle();
        chk("home_addr_idx", {25'd0, cursor_idx}, 32'd0);
        check_ram("cgram_ram");
        chk("no_timing_err", {31'd0, timing_err}, 32'd0);

        send_byte(1'b0, 8'h01);
        fork
            measure_busy("clear_busy_len", 41000);
            begin
                repeat (3000) @(negedge clk);
                send_nib(1'b0, 4'h0);
                chk("busy_violation_err", {31'd0, timing_err}, 32'd1);
            end
        join
        for (int i = 0; i < 80; i++) exp_ram[i] = 8'h20;
        check_ram("clear_ram");
        chk("clear_cursor_idx", {25'd0, cursor_idx}, 32'd0);

        exp_q.push_back({1'b0, 8'h06});
        send_nib(1'b0, 4'h6);
        wait_idle();
        send_byte(1'b1, 8'h5A); wait_idle();
        read_chk("pre_reset_ram0", 0, 8'h5A);
        send_nib(1'b0, 4'h3);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_four_bit", {31'd0, four_bit_mode}, 32'd0);
        chk("midrst_timing_err", {31'd0, timing_err}, 32'd0);
        bench4 = 1'b0;
        rst_n = 1'b1;
        wait_fill("refill_len");
        check_ram("refill_ram");

        send_byte(1'b0, 8'h20); wait_idle();
        bench4 = 1'b1;
        send_byte(1'b0, 8'h0F); wait_idle();
        chk("phase_display_on", {31'd0, display_on}, 32'd1);
        chk("phase_cursor_on", {31'd0, cursor_on}, 32'd1);
        chk("phase_blink_on", {31'd0, blink_on}, 32'd1);

        repeat (5) @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
